// File: rtl/lfsr_map_pkg.sv
// Shared constants for the count-to-LFSR-seed mapper: FSM encoding and
// default XNOR feedback masks per register width.
package lfsr_map_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    // Maximal-length tap sets; unknown widths fall back to the top two bits.
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            16:      return 32'h0000_B400;
            default: return 32'd3 << (width - 2);
        endcase
    endfunction

endpackage

// File: rtl/lfsr_seed_map_core.sv
// Generic XNOR Fibonacci shifter: clears to zero, advances one step when asked.
module lfsr_core
    import lfsr_map_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             step,
    output logic [WIDTH-1:0] sr
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (step) begin
            sr <= {sr[WIDTH-2:0], ~^(sr & TAPS)};
        end
    end

endmodule

// File: rtl/lfsr_seed_map.sv
// Maps a divide count N to the preload {sr, N[0]} of a WIDTH-bit XNOR LFSR
// divider by stepping a local LFSR a count-derived number of times.
module lfsr_seed_map
    import lfsr_map_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
    parameter int               LOAD_OFFSET = 3,
    parameter bit               AUTO_START  = 1'b1,
    parameter bit               RESTART_EN  = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH:0]   N,
    output logic [WIDTH:0]   dp,
    output logic             done,
    output logic             done_pulse,
    output logic             busy,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] sr,
    output logic [2:0]       state
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] OFFSET   = WIDTH'(LOAD_OFFSET);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Handshake: every rising edge of start requests one conversion; dp is
    // valid whenever done is high, and done_pulse marks the cycle it rises.
    // Requests arriving while busy either restart or queue (depth one).
    logic [1:0]       startbuf;
    logic             pending;
    logic             n_lsb;
    logic             start_edge;
    logic             restart_hit;
    logic             queue_hit;
    logic [2:0]       state_nxt;
    logic             do_load;
    logic             sr_step;
    logic             do_capture;
    logic             do_finish;
    logic [WIDTH-1:0] load_val;

    assign start_edge  = (startbuf == 2'b01);
    assign restart_hit = RESTART_EN && start_edge && (state != ST_WAIT);
    assign queue_hit   = !RESTART_EN && start_edge;
    assign load_val    = ALL_ONES - N[WIDTH:1] + OFFSET;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (do_load),
        .step    (sr_step),
        .sr      (sr)
    );

    always_comb begin
        state_nxt  = state;
        do_load    = 1'b0;
        sr_step    = 1'b0;
        do_capture = 1'b0;
        do_finish  = 1'b0;
        case (state)
            ST_WAIT: begin
                if (start_edge || pending) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                do_load   = 1'b1;
                state_nxt = restart_hit ? ST_LOAD : ST_RUN;
            end
            ST_RUN: begin
                if (restart_hit) begin
                    state_nxt = ST_LOAD;
                end else begin
                    sr_step = 1'b1;
                    if (counter == '0) state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (restart_hit) begin
                    state_nxt = ST_LOAD;
                end else begin
                    do_capture = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart_hit) begin
                    state_nxt = ST_LOAD;
                end else begin
                    do_finish = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= AUTO_START ? ST_LOAD : ST_WAIT;
            startbuf   <= 2'b00;
            pending    <= 1'b0;
            n_lsb      <= 1'b0;
            counter    <= '0;
            dp         <= '0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            startbuf   <= {startbuf[0], start};
            done_pulse <= do_finish;
            busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN) ||
                          (state_nxt == ST_CAPTURE);

            // The counter wraps only on the final RUN decrement.
            if (do_load) begin
                counter <= load_val;
                n_lsb   <= N[0];
                done    <= 1'b0;
            end else if (sr_step) begin
                counter <= counter - ONE;
            end

            if (do_capture) dp <= {sr, n_lsb};
            if (do_finish) done <= 1'b1;

            if (state == ST_WAIT) begin
                pending <= 1'b0;
            end else if (queue_hit) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seed_map.sv
// Bench for lfsr_seed_map: three instances (auto/queue, wait/queue, auto/restart)
// checked every cycle against a countdown-based model of the conversion.
module tb_lfsr_seed_map;
    import lfsr_map_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [2:0]   start_v;
    logic [W:0]   n_in;
    logic [W:0]   dp_o   [3];
    logic [2:0]   done_o;
    logic [2:0]   pulse_o;
    logic [2:0]   busy_o;
    logic [W-1:0] cnt_o  [3];
    logic [W-1:0] sr_o   [3];
    logic [2:0]   st_o   [3];

    int n_err = 0;
    int n_chk = 0;
    int cnt;

    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    lfsr_seed_map #(.WIDTH(W), .AUTO_START(1'b1), .RESTART_EN(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .N(n_in),
        .dp(dp_o[0]), .done(done_o[0]), .done_pulse(pulse_o[0]), .busy(busy_o[0]),
        .counter(cnt_o[0]), .sr(sr_o[0]), .state(st_o[0]));

    lfsr_seed_map #(.WIDTH(W), .AUTO_START(1'b0), .RESTART_EN(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .N(n_in),
        .dp(dp_o[1]), .done(done_o[1]), .done_pulse(pulse_o[1]), .busy(busy_o[1]),
        .counter(cnt_o[1]), .sr(sr_o[1]), .state(st_o[1]));

    lfsr_seed_map #(.WIDTH(W), .AUTO_START(1'b1), .RESTART_EN(1'b1)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .N(n_in),
        .dp(dp_o[2]), .done(done_o[2]), .done_pulse(pulse_o[2]), .busy(busy_o[2]),
        .counter(cnt_o[2]), .sr(sr_o[2]), .state(st_o[2]));

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lfsr_after(input int k);
        logic [W-1:0] s;
        s = '0;
        for (int j = 0; j < k; j++) s = {s[W-2:0], ~^(s & 8'hB8)};
        return s;
    endfunction

    function automatic int load_of(input logic [W:0] n);
        return (255 - int'(n[W:1]) + 3) % 256;
    endfunction

    // ---------------- behavioural model ----------------
    // A conversion is a LOAD edge followed by a countdown of (load+3) edges:
    // load+1 shifts, one capture edge, one done edge.
    logic [W:0] m_dp  [3];
    logic [W:0] m_job [3];
    bit         m_done [3];
    bit         m_pulse [3];
    bit         m_busy [3];
    bit         m_loading [3];
    bit         m_pend [3];
    bit         h_old [3];
    bit         h_new [3];
    int         m_left [3];
    int         m_ld [3];

    logic [W:0] n_smp;
    logic [2:0] st_smp;
    logic       rst_smp;

    always @(posedge clock) begin
        n_smp   <= n_in;
        st_smp  <= start_v;
        rst_smp <= reset_n;
    end

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_dp[i] = '0; m_job[i] = '0; m_done[i] = 0; m_pulse[i] = 0;
            m_busy[i] = 0; m_pend[i] = 0; h_old[i] = 0; h_new[i] = 0;
            m_left[i] = 0; m_ld[i] = 0;
            m_loading[i] = (i != 1);
        end
    endtask

    task automatic model_step(input int i);
        bit edge_now;
        bit active;
        bit ren;
        edge_now   = !h_old[i] && h_new[i];
        active     = m_loading[i] || (m_left[i] > 0);
        ren        = (i == 2);
        m_pulse[i] = 0;
        if (m_loading[i]) begin
            m_ld[i]   = load_of(n_smp);
            m_job[i]  = {lfsr_after(m_ld[i] + 1), n_smp[0]};
            m_done[i] = 0;
            if (!(ren && edge_now)) begin
                m_loading[i] = 0;
                m_left[i]    = m_ld[i] + 3;
            end
        end else if (m_left[i] > 0) begin
            if (ren && edge_now) begin
                m_left[i]    = 0;
                m_loading[i] = 1;
            end else begin
                if (m_left[i] == 2) m_dp[i] = m_job[i];
                if (m_left[i] == 1) begin
                    m_done[i]  = 1;
                    m_pulse[i] = 1;
                end
                m_left[i]--;
            end
        end else if (edge_now || m_pend[i]) begin
            m_loading[i] = 1;
            m_pend[i]    = 0;
        end
        if (active && edge_now && !ren) m_pend[i] = 1;
        m_busy[i] = m_loading[i] || (m_left[i] >= 2);
        h_old[i]  = h_new[i];
        h_new[i]  = st_smp[i];
    endtask

    // Single compare process: advance the model by the last edge, then check.
    always @(negedge clock) begin
        if (!reset_n) model_reset();
        else if (rst_smp === 1'b1) for (int i = 0; i < 3; i++) model_step(i);
        for (int i = 0; i < 3; i++) begin
            chk("dp", i, 32'(dp_o[i]), 32'(m_dp[i]));
            chk("done", i, 32'(done_o[i]), 32'(m_done[i]));
            chk("done_pulse", i, 32'(pulse_o[i]), 32'(m_pulse[i]));
            chk("busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
            if (!m_loading[i] && m_left[i] >= 2) begin
                int k;
                k = m_ld[i] + 3 - m_left[i];
                chk("sr_run", i, 32'(sr_o[i]), 32'(lfsr_after(k)));
                chk("counter_run", i, 32'(cnt_o[i]), 32'((m_ld[i] - k) & 255));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        @(negedge clock);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_busy(input int i, input int max);
        for (int c = 0; c < max && busy_o[i] !== 1'b1; c++) @(negedge clock);
        chk("wait_busy", i, 32'(busy_o[i]), 1);
    endtask

    task automatic wait_pulse(input int i, input int max);
        for (int c = 0; c < max && pulse_o[i] !== 1'b1; c++) @(negedge clock);
        chk("wait_pulse", i, 32'(pulse_o[i]), 1);
    endtask

    task automatic count_pulses(input int i, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clock);
            n += int'(pulse_o[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        start_v = '0;
        n_in    = 9'h1FE;

        chk("model_lfsr4", 0, 32'(lfsr_after(4)), 32'h0F);
        chk("model_lfsr3", 0, 32'(lfsr_after(3)), 32'h07);
        chk("model_load_1fe", 0, load_of(9'h1FE), 3);
        chk("model_load_000", 0, load_of(9'h000), 2);

        repeat (2) @(negedge clock);
        chk("rst_state_auto", 0, 32'(st_o[0]), 32'(ST_LOAD));
        chk("rst_state_wait", 1, 32'(st_o[1]), 32'(ST_WAIT));
        chk("rst_busy", 0, 32'(busy_o[0]), 0);
        reset_n = 1'b1;

        // AUTO_START run with N=1FE: done on the 7th edge
        repeat (6) @(negedge clock);
        chk("auto_done_edge6", 0, 32'(done_o[0]), 0);
        @(negedge clock);
        chk("auto_done_edge7", 0, 32'(done_o[0]), 1);
        chk("auto_pulse_edge7", 0, 32'(pulse_o[0]), 1);
        chk("auto_dp", 0, 32'(dp_o[0]), 32'h01E);
        chk("auto_dp", 2, 32'(dp_o[2]), 32'h01E);
        @(negedge clock);
        chk("auto_pulse_gone", 0, 32'(pulse_o[0]), 0);
        chk("auto_done_held", 0, 32'(done_o[0]), 1);
        chk("wait_mode_idle", 1, 32'(done_o[1]), 0);

        // load value wrap and N[0] pass-through
        n_in = 9'h000;
        pulse_start(0);
        wait_pulse(0, 30);
        chk("n000_dp", 0, 32'(dp_o[0]), 32'h00E);
        @(negedge clock);
        n_in = 9'h001;
        pulse_start(0);
        wait_pulse(0, 30);
        chk("n001_dp", 0, 32'(dp_o[0]), 32'h00F);

        // WAIT mode: start held high gives exactly one conversion
        @(negedge clock);
        n_in = 9'h1FE;
        start_v[1] = 1'b1;
        count_pulses(1, 40, cnt);
        chk("b_held_one_conv", 1, cnt, 1);
        chk("b_dp", 1, 32'(dp_o[1]), 32'h01E);
        start_v[1] = 1'b0;
        @(negedge clock);
        start_v[1] = 1'b1;
        wait_busy(1, 10);
        @(negedge clock);
        chk("b_done_cleared_by_load", 1, 32'(done_o[1]), 0);
        wait_pulse(1, 30);
        chk("b_second_dp", 1, 32'(dp_o[1]), 32'h01E);
        start_v[1] = 1'b0;

        // queued request during RUN
        @(negedge clock);
        pulse_start(0);
        wait_busy(0, 10);
        pulse_start(0);
        wait_pulse(0, 30);
        chk("q_first_dp", 0, 32'(dp_o[0]), 32'h01E);
        @(negedge clock);
        chk("q_second_starts", 0, 32'(busy_o[0]), 1);
        wait_pulse(0, 30);
        count_pulses(0, 20, cnt);
        chk("q_no_third", 0, cnt, 0);

        // restart during RUN with a new N
        n_in = 9'h1FE;
        pulse_start(2);
        wait_busy(2, 10);
        @(negedge clock);
        start_v[2] = 1'b1;
        n_in = 9'h1FF;
        @(negedge clock);
        start_v[2] = 1'b0;
        count_pulses(2, 30, cnt);
        chk("r_single_done", 2, cnt, 1);
        chk("r_dp", 2, 32'(dp_o[2]), 32'h01F);

        // asynchronous reset mid-RUN, then a fresh auto run
        @(negedge clock);
        n_in = 9'h1FE;
        pulse_start(0);
        wait_busy(0, 10);
        repeat (2) @(negedge clock);
        chk("mid_run_busy", 0, 32'(busy_o[0]), 1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_dp", 0, 32'(dp_o[0]), 0);
        chk("async_rst_busy", 0, 32'(busy_o[0]), 0);
        chk("async_rst_sr", 0, 32'(sr_o[0]), 0);
        chk("async_rst_counter", 0, 32'(cnt_o[0]), 0);
        chk("async_rst_done", 0, 32'(done_o[0]), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("rerun_done_edge6", 0, 32'(done_o[0]), 0);
        @(negedge clock);
        chk("rerun_done_edge7", 0, 32'(done_o[0]), 1);
        chk("rerun_dp", 0, 32'(dp_o[0]), 32'h01E);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
